// File: rtl/byte_unstriping_nlane.sv
// N-lane byte un-striper: per-lane FIFOs absorb lane skew, a round-robin reader restores word order.
// Define UNSTRIPE_ERR_EN to add the sticky overflow_err flags and the out_lane source tag.
module byte_unstriping_nlane #(
    parameter int NUM_LANES = 4,
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_LANES-1:0]           valid_in,
    input  logic [NUM_LANES*WIDTH-1:0]     lane_in,
    output logic [NUM_LANES-1:0]           lane_ready,
    input  logic                           align,
    input  logic                           out_ready,
    output logic [WIDTH-1:0]               data_out,
    output logic                           valid_out
`ifdef UNSTRIPE_ERR_EN
    ,
    output logic [NUM_LANES-1:0]           overflow_err,
    output logic [$clog2(NUM_LANES)-1:0]   out_lane
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(NUM_LANES);
    localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);
    localparam logic [LW-1:0] LAST_LANE  = LW'(NUM_LANES - 1);

    logic [WIDTH-1:0] mem    [NUM_LANES][DEPTH];
    logic [AW-1:0]    wr_ptr [NUM_LANES];
    logic [AW-1:0]    rd_ptr [NUM_LANES];
    logic [AW:0]      count  [NUM_LANES];
    logic [LW-1:0]    rr;

    logic [NUM_LANES-1:0] push;
    logic [NUM_LANES-1:0] pop;
    logic                 head_valid;
    logic                 load;
    logic                 flush;

    // lane_ready looks only at the pre-edge count, so a same-cycle pop never frees room for a push
    always_comb begin
        flush = reset || align;
        for (int i = 0; i < NUM_LANES; i++) begin
            lane_ready[i] = (count[i] != FULL_COUNT);
        end
        push       = valid_in & lane_ready & {NUM_LANES{~flush}};
        head_valid = (count[rr] != '0);
        load       = head_valid && (!valid_out || out_ready);
        pop        = '0;
        if (load) begin
            pop[rr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_LANES; i++) begin
            if (push[i]) begin
                mem[i][wr_ptr[i]] <= lane_in[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
            rr        <= '0;
            valid_out <= 1'b0;
            data_out  <= '0;
        end else begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (push[i]) begin
                    wr_ptr[i] <= wr_ptr[i] + 1'b1;
                end
                if (pop[i]) begin
                    rd_ptr[i] <= rd_ptr[i] + 1'b1;
                end
                if (push[i] && !pop[i]) begin
                    count[i] <= count[i] + 1'b1;
                end else if (pop[i] && !push[i]) begin
                    count[i] <= count[i] - 1'b1;
                end
            end
            // Strict ordering: rr only advances on a load, so an empty head lane stalls the output
            if (load) begin
                data_out  <= mem[rr][rd_ptr[rr]];
                valid_out <= 1'b1;
                rr        <= (rr == LAST_LANE) ? '0 : rr + 1'b1;
            end else if (out_ready) begin
                valid_out <= 1'b0;
            end
        end
    end

`ifdef UNSTRIPE_ERR_EN
    always_ff @(posedge clk) begin
        if (flush) begin
            overflow_err <= '0;
            out_lane     <= '0;
        end else begin
            overflow_err <= overflow_err | (valid_in & ~lane_ready);
            if (load) begin
                out_lane <= rr;
            end
        end
    end
`endif

endmodule

// File: tb/tb_byte_unstriping_nlane.sv
// Self-checking bench for byte_unstriping_nlane: queue-based reference model plus a 2-lane byte instance.
// Build with UNSTRIPE_ERR_EN defined to also check overflow_err and out_lane.
module tb_byte_unstriping_nlane;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int D  = 4;
    localparam int N2 = 2;
    localparam int W2 = 8;
    localparam int D2 = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset;
    logic             align;
    logic             out_ready;
    logic [N-1:0]     valid_in;
    logic [N*W-1:0]   lane_in;
    logic [N-1:0]     lane_ready;
    logic [W-1:0]     data_out;
    logic             valid_out;

    logic             n_reset;
    logic             n_align;
    logic             n_out_ready;
    logic [N2-1:0]    n_valid_in;
    logic [N2*W2-1:0] n_lane_in;
    logic [N2-1:0]    n_lane_ready;
    logic [W2-1:0]    n_data_out;
    logic             n_valid_out;

`ifdef UNSTRIPE_ERR_EN
    logic [N-1:0]     overflow_err;
    logic [1:0]       out_lane;
    logic [N2-1:0]    n_overflow_err;
    logic [0:0]       n_out_lane;
`endif

    byte_unstriping_nlane #(.NUM_LANES(N), .WIDTH(W), .DEPTH(D)) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .lane_in(lane_in),
        .lane_ready(lane_ready), .align(align), .out_ready(out_ready),
        .data_out(data_out), .valid_out(valid_out)
`ifdef UNSTRIPE_ERR_EN
        , .overflow_err(overflow_err), .out_lane(out_lane)
`endif
    );

    byte_unstriping_nlane #(.NUM_LANES(N2), .WIDTH(W2), .DEPTH(D2)) dut_narrow (
        .clk(clk), .reset(n_reset), .valid_in(n_valid_in), .lane_in(n_lane_in),
        .lane_ready(n_lane_ready), .align(n_align), .out_ready(n_out_ready),
        .data_out(n_data_out), .valid_out(n_valid_out)
`ifdef UNSTRIPE_ERR_EN
        , .overflow_err(n_overflow_err), .out_lane(n_out_lane)
`endif
    );

    // Reference model: one queue per lane plus the visible output register
    logic [W-1:0] mq [N][$];
    int           m_rr;
    bit           m_valid;
    logic [W-1:0] m_data;
    logic [N-1:0] m_err;
    int           m_lane;
    int           m_pushed;

    int vectors;
    int miscompares;
    logic [W-1:0] got [$];

    function automatic logic [N-1:0] model_ready();
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = (mq[i].size() < D);
        return r;
    endfunction

    function automatic logic [N*W-1:0] pack4(input logic [W-1:0] w0, input logic [W-1:0] w1,
                                             input logic [W-1:0] w2, input logic [W-1:0] w3);
        return {w3, w2, w1, w0};
    endfunction

    function automatic logic [N*W-1:0] rand_lanes();
        logic [N*W-1:0] r;
        for (int i = 0; i < N; i++) r[i*W +: W] = $urandom;
        return r;
    endfunction

    // Drives one cycle on the main DUT, advances the model, and returns #1 after the edge
    task automatic applyStimulus(input logic [N-1:0] vin, input logic [N*W-1:0] din,
                                 input bit al, input bit ordy, input bit rst);
        bit full [N];
        bit ld;
        if (valid_out === 1'b1 && ordy) got.push_back(data_out);
        valid_in  = vin;
        lane_in   = din;
        align     = al;
        out_ready = ordy;
        reset     = rst;
        if (rst || al) begin
            for (int i = 0; i < N; i++) mq[i].delete();
            m_rr = 0; m_valid = 0; m_data = '0; m_err = '0; m_lane = 0;
        end else begin
            for (int i = 0; i < N; i++) full[i] = (mq[i].size() >= D);
            ld = (mq[m_rr].size() != 0) && (!m_valid || ordy);
            if (ld) begin
                m_data  = mq[m_rr].pop_front();
                m_valid = 1;
                m_lane  = m_rr;
                m_rr    = (m_rr + 1) % N;
            end else if (ordy) begin
                m_valid = 0;
            end
            for (int i = 0; i < N; i++) begin
                if (vin[i]) begin
                    if (full[i]) m_err[i] = 1'b1;
                    else begin
                        mq[i].push_back(din[i*W +: W]);
                        m_pushed++;
                    end
                end
            end
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        align = 1'b0;
    endtask

    task automatic test_reset();
        applyStimulus('1, rand_lanes(), 1'b1, 1'b1, 1'b1);
        vectors++;
        if (valid_out !== 1'b0 || data_out !== '0 || lane_ready !== 4'b1111) begin
            miscompares++;
            $display("[TB] FAIL reset_state: got v=%b d=%h rdy=%b, want v=0 d=0 rdy=1111",
                     valid_out, data_out, lane_ready);
        end
        applyStimulus('0, '0, 1'b0, 1'b1, 1'b0);
        vectors++;
        if (valid_out !== 1'b0 || lane_ready !== 4'b1111) begin
            miscompares++;
            $display("[TB] FAIL reset_nocapture: got v=%b rdy=%b, want v=0 rdy=1111",
                     valid_out, lane_ready);
        end
`ifdef UNSTRIPE_ERR_EN
        vectors++;
        if (overflow_err !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_err: got %b, want 0000", overflow_err);
        end
`endif
    endtask

    task automatic test_aligned();
        got.delete();
        for (int c = 0; c < 12; c++) begin
            if (c == 0)      applyStimulus('1, pack4(0, 1, 2, 3), 1'b0, 1'b1, 1'b0);
            else if (c == 1) applyStimulus('1, pack4(4, 5, 6, 7), 1'b0, 1'b1, 1'b0);
            else             applyStimulus('0, '0, 1'b0, 1'b1, 1'b0);
            vectors++;
            if (valid_out !== m_valid || (m_valid && data_out !== m_data) || lane_ready !== model_ready()) begin
                miscompares++;
                $display("[TB] FAIL aligned c%0d: got v=%b d=%h rdy=%b, want v=%b d=%h rdy=%b",
                         c, valid_out, data_out, lane_ready, m_valid, m_data, model_ready());
            end
            if (c == 0) begin
                vectors++;
                if (valid_out !== 1'b0) begin
                    miscompares++;
                    $display("[TB] FAIL aligned_latency: got v=%b, want v=0", valid_out);
                end
            end
        end
        vectors++;
        if (got.size() != 8 || valid_out !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL aligned_count: got %0d words v=%b, want 8 words v=0", got.size(), valid_out);
        end else begin
            for (int i = 0; i < 8; i++) begin
                vectors++;
                if (got[i] !== 32'(i)) begin
                    miscompares++;
                    $display("[TB] FAIL aligned_word%0d: got %h, want %h", i, got[i], i);
                end
            end
        end
    endtask

    task automatic test_skew();
        logic [W-1:0] exp_w;
        got.delete();
        for (int c = 0; c < 12; c++) begin
            case (c)
                0:       applyStimulus(4'b1011, pack4('hA0, 'hA1, 0, 'hA3), 1'b0, 1'b1, 1'b0);
                1:       applyStimulus(4'b1011, pack4('hA4, 'hA5, 0, 'hA7), 1'b0, 1'b1, 1'b0);
                3:       applyStimulus(4'b0100, pack4(0, 0, 'hA2, 0), 1'b0, 1'b1, 1'b0);
                4:       applyStimulus(4'b0100, pack4(0, 0, 'hA6, 0), 1'b0, 1'b1, 1'b0);
                default: applyStimulus('0, '0, 1'b0, 1'b1, 1'b0);
            endcase
            vectors++;
            if (valid_out !== m_valid || (m_valid && data_out !== m_data) || lane_ready !== 4'b1111) begin
                miscompares++;
                $display("[TB] FAIL skew c%0d: got v=%b d=%h rdy=%b, want v=%b d=%h rdy=1111",
                         c, valid_out, data_out, lane_ready, m_valid, m_data);
            end
        end
        vectors++;
        if (got.size() != 8) begin
            miscompares++;
            $display("[TB] FAIL skew_count: got %0d words, want 8", got.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                exp_w = 32'hA0 + 32'(i);
                vectors++;
                if (got[i] !== exp_w) begin
                    miscompares++;
                    $display("[TB] FAIL skew_word%0d: got %h, want %h", i, got[i], exp_w);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] held;
        int start_pushed;
        got.delete();
        start_pushed = m_pushed;
        for (int c = 0; c < 2; c++) applyStimulus('1, rand_lanes(), 1'b0, 1'b1, 1'b0);
        held = data_out;
        for (int c = 0; c < 6; c++) begin
            applyStimulus('1, rand_lanes(), 1'b0, 1'b0, 1'b0);
            vectors++;
            if (valid_out !== 1'b1 || data_out !== held || lane_ready !== model_ready()) begin
                miscompares++;
                $display("[TB] FAIL hold c%0d: got v=%b d=%h rdy=%b, want v=1 d=%h rdy=%b",
                         c, valid_out, data_out, lane_ready, held, model_ready());
            end
        end
        vectors++;
        if (lane_ready !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL bp_full: got rdy=%b, want 0000", lane_ready);
        end
`ifdef UNSTRIPE_ERR_EN
        vectors++;
        if (overflow_err !== 4'b1111) begin
            miscompares++;
            $display("[TB] FAIL bp_err: got %b, want 1111", overflow_err);
        end
`endif
        for (int c = 0; c < 22; c++) begin
            applyStimulus('0, '0, 1'b0, 1'b1, 1'b0);
            vectors++;
            if (valid_out !== m_valid || (m_valid && data_out !== m_data)) begin
                miscompares++;
                $display("[TB] FAIL drain c%0d: got v=%b d=%h, want v=%b d=%h",
                         c, valid_out, data_out, m_valid, m_data);
            end
        end
        vectors++;
        if (got.size() != m_pushed - start_pushed) begin
            miscompares++;
            $display("[TB] FAIL bp_count: got %0d words, want %0d", got.size(), m_pushed - start_pushed);
        end
        for (int i = 0; i < got.size(); i++) begin
            for (int j = i + 1; j < got.size(); j++) begin
                if (got[i] === got[j]) begin
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL bp_dup: word %h at %0d and %0d", got[i], i, j);
                end
            end
        end
    endtask

    task automatic test_align();
        got.delete();
        applyStimulus(4'b0111, pack4('h51, 'h52, 'h53, 0), 1'b0, 1'b0, 1'b0);
        applyStimulus('0, '0, 1'b0, 1'b0, 1'b0);
        applyStimulus('1, rand_lanes(), 1'b1, 1'b0, 1'b0);
        vectors++;
        if (valid_out !== 1'b0 || lane_ready !== 4'b1111) begin
            miscompares++;
            $display("[TB] FAIL align_clear: got v=%b rdy=%b, want v=0 rdy=1111", valid_out, lane_ready);
        end
        got.delete();
        for (int c = 0; c < 8; c++) begin
            if (c == 0) applyStimulus('1, pack4('h10, 'h11, 'h12, 'h13), 1'b0, 1'b1, 1'b0);
            else        applyStimulus('0, '0, 1'b0, 1'b1, 1'b0);
        end
        vectors++;
        if (got.size() != 4) begin
            miscompares++;
            $display("[TB] FAIL align_count: got %0d words, want 4", got.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                vectors++;
                if (got[i] !== 32'h10 + 32'(i)) begin
                    miscompares++;
                    $display("[TB] FAIL align_word%0d: got %h, want %h", i, got[i], 32'h10 + 32'(i));
                end
            end
        end
    endtask

    task automatic test_random();
        logic [N-1:0] vin;
        bit al, ordy;
        for (int c = 0; c < 400; c++) begin
            vin  = N'($urandom);
            al   = ($urandom_range(0, 39) == 0);
            ordy = ($urandom_range(0, 3) != 0);
            applyStimulus(vin, rand_lanes(), al, ordy, 1'b0);
            vectors++;
            if (valid_out !== m_valid || (m_valid && data_out !== m_data) || lane_ready !== model_ready()) begin
                miscompares++;
                $display("[TB] FAIL random c%0d: got v=%b d=%h rdy=%b, want v=%b d=%h rdy=%b",
                         c, valid_out, data_out, lane_ready, m_valid, m_data, model_ready());
            end
`ifdef UNSTRIPE_ERR_EN
            vectors++;
            if (overflow_err !== m_err || (m_valid && out_lane !== 2'(m_lane))) begin
                miscompares++;
                $display("[TB] FAIL random_err c%0d: got err=%b lane=%0d, want err=%b lane=%0d",
                         c, overflow_err, out_lane, m_err, m_lane);
            end
`endif
        end
    endtask

    task automatic test_narrow();
        logic [W2-1:0] ngot [$];
        logic [W2-1:0] nexp [4];
        logic [W2-1:0] prev_d;
        bit prev_v, ordy;
        nexp[0] = 8'h11; nexp[1] = 8'h22; nexp[2] = 8'h33; nexp[3] = 8'h44;
        n_reset = 1'b1;
        @(posedge clk); #1;
        n_reset = 1'b0;
        vectors++;
        if (n_valid_out !== 1'b0 || n_lane_ready !== 2'b11) begin
            miscompares++;
            $display("[TB] FAIL narrow_reset: got v=%b rdy=%b, want v=0 rdy=11", n_valid_out, n_lane_ready);
        end
        for (int c = 0; c < 14; c++) begin
            ordy = (c % 2 == 0);
            if (n_valid_out === 1'b1 && ordy) ngot.push_back(n_data_out);
            prev_v = n_valid_out;
            prev_d = n_data_out;
            n_out_ready = ordy;
            if (c == 0)      begin n_valid_in = 2'b11; n_lane_in = {8'h22, 8'h11}; end
            else if (c == 1) begin n_valid_in = 2'b11; n_lane_in = {8'h44, 8'h33}; end
            else             begin n_valid_in = 2'b00; n_lane_in = '0; end
            @(posedge clk); #1;
            if (prev_v && !ordy) begin
                vectors++;
                if (n_valid_out !== 1'b1 || n_data_out !== prev_d) begin
                    miscompares++;
                    $display("[TB] FAIL narrow_hold c%0d: got v=%b d=%h, want v=1 d=%h",
                             c, n_valid_out, n_data_out, prev_d);
                end
            end
        end
        vectors++;
        if (ngot.size() != 4) begin
            miscompares++;
            $display("[TB] FAIL narrow_count: got %0d words, want 4", ngot.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                vectors++;
                if (ngot[i] !== nexp[i]) begin
                    miscompares++;
                    $display("[TB] FAIL narrow_word%0d: got %h, want %h", i, ngot[i], nexp[i]);
                end
            end
        end
    endtask

    initial begin
        vectors = 0; miscompares = 0; m_pushed = 0;
        reset = 1'b1; align = 1'b0; out_ready = 1'b1; valid_in = '0; lane_in = '0;
        n_reset = 1'b1; n_align = 1'b0; n_out_ready = 1'b1; n_valid_in = '0; n_lane_in = '0;
        @(posedge clk); #1;
        test_reset();
        test_aligned();
        test_skew();
        test_backpressure();
        test_align();
        test_random();
        test_reset();
        test_narrow();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
